// File: rtl/rvj1_hazard_ctrl_pkg.sv
// Shared types and defaults for the rvj1 decode-stage hazard controller.
// Holds the drain FSM encoding and the default ALU latency / load depth.
package rvj1_defines;

   typedef enum logic {
      HZD_RUN   = 1'b0,
      HZD_DRAIN = 1'b1
   } hzd_state_e;

   typedef logic [4:0] reg_idx_t;

   localparam int ALU_LAT_DEF   = 1;
   localparam int MAX_LOADS_DEF = 2;
   localparam int NUM_REGS      = 32;

   // One-hot of a register index; x0 maps to nothing so it is never tracked.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx, input logic en);
      logic [NUM_REGS-1:0] oh;
      oh = '0;
      if (en && (idx != 5'd0)) oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rvj1_hazard_ctrl_if.sv
// Decoder / LSU facing signal bundle of the hazard controller.
// master = decoder+LSU side, slave = hazard controller.
interface rvj1_hazard_ctrl_if;
   import rvj1_defines::*;

   logic       dec_valid_i;
   reg_idx_t   dec_rs1_i;
   logic       dec_rs1_used_i;
   reg_idx_t   dec_rs2_i;
   logic       dec_rs2_used_i;
   reg_idx_t   dec_rd_i;
   logic       dec_wr_alu_i;
   logic       dec_wr_lsu_i;
   logic       dec_fence_i;
   logic       lsu_wb_valid_i;
   reg_idx_t   lsu_wb_rd_i;
   logic       lsu_busy_i;
   logic       stall_o;
   logic       issue_o;
   logic       busy_o;
   logic [2:0] loads_out_o;

   modport master (
      output dec_valid_i, dec_rs1_i, dec_rs1_used_i, dec_rs2_i, dec_rs2_used_i,
             dec_rd_i, dec_wr_alu_i, dec_wr_lsu_i, dec_fence_i,
             lsu_wb_valid_i, lsu_wb_rd_i, lsu_busy_i,
      input  stall_o, issue_o, busy_o, loads_out_o
   );

   modport slave (
      input  dec_valid_i, dec_rs1_i, dec_rs1_used_i, dec_rs2_i, dec_rs2_used_i,
             dec_rd_i, dec_wr_alu_i, dec_wr_lsu_i, dec_fence_i,
             lsu_wb_valid_i, lsu_wb_rd_i, lsu_busy_i,
      output stall_o, issue_o, busy_o, loads_out_o
   );

endinterface

// File: rtl/rvj1_alu_wb_pipe.sv
// ALU_LAT-deep valid/rd shift register marking when an ALU result reaches the RF.
// Latency ALU_LAT cycles from entry to exit; no backpressure, shifts every cycle.
module rvj1_alu_wb_pipe
   import rvj1_defines::*;
#(
   parameter int ALU_LAT = ALU_LAT_DEF
) (
   input  logic     clk_i,
   input  logic     rstn_i,
   input  logic     in_vld_i,
   input  reg_idx_t in_rd_i,
   output logic     out_vld_o,
   output reg_idx_t out_rd_o
);

   logic [ALU_LAT-1:0]      vld_q, vld_d;
   logic [ALU_LAT-1:0][4:0] rd_q,  rd_d;

   always_comb begin
      vld_d    = '0;
      rd_d     = '0;
      vld_d[0] = in_vld_i;
      rd_d[0]  = in_rd_i;
      for (int i = 1; i < ALU_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         rd_d[i]  = rd_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_q <= '0;
         rd_q  <= '0;
      end else begin
         vld_q <= vld_d;
         rd_q  <= rd_d;
      end
   end

   assign out_vld_o = vld_q[ALU_LAT-1];
   assign out_rd_o  = rd_q[ALU_LAT-1];

endmodule

// File: rtl/rvj1_hazard_ctrl.sv
// Scoreboard issue controller: RAW/WAW/load-limit stalls plus fence drain FSM.
// Stall is combinational from registered state; issue = dec_valid & ~stall.
module rvj1_hazard_ctrl
   import rvj1_defines::*;
#(
   parameter int ALU_LAT   = ALU_LAT_DEF,
   parameter int MAX_LOADS = MAX_LOADS_DEF
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   rvj1_hazard_ctrl_if.slave  hz
);

   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic [NUM_REGS-1:0] own_q,  own_d;
   logic [2:0]          cnt_q,  cnt_d;
   hzd_state_e          state_q, state_d;

   logic     raw, waw, ldfull, lsubusy, fence_stall, stall, issue, busy;
   logic     wr_any, wb_ok, ld_inc, alu_in_vld, alu_exit_vld;
   reg_idx_t alu_exit_rd;

   always_comb begin
      busy    = |pend_q;
      wr_any  = hz.dec_wr_alu_i | hz.dec_wr_lsu_i;
      raw     = (hz.dec_rs1_used_i & pend_q[hz.dec_rs1_i]) |
                (hz.dec_rs2_used_i & pend_q[hz.dec_rs2_i]);
      waw     = wr_any & pend_q[hz.dec_rd_i];
      ldfull  = hz.dec_wr_lsu_i & (cnt_q == 3'(MAX_LOADS));
      lsubusy = hz.dec_wr_lsu_i & hz.lsu_busy_i;
      // A fence arriving while writes are pending is held here; DRAIN takes over next cycle.
      fence_stall = (state_q == HZD_DRAIN) | (hz.dec_fence_i & busy);
      stall   = hz.dec_valid_i & (raw | waw | ldfull | lsubusy | fence_stall);
      issue   = hz.dec_valid_i & ~stall;
   end

   rvj1_alu_wb_pipe #(.ALU_LAT(ALU_LAT)) u_alu_pipe (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .in_vld_i  (alu_in_vld),
      .in_rd_i   (hz.dec_rd_i),
      .out_vld_o (alu_exit_vld),
      .out_rd_o  (alu_exit_rd)
   );

   assign alu_in_vld = issue & hz.dec_wr_alu_i & (hz.dec_rd_i != 5'd0);

   always_comb begin
      // Write-backs that do not match an LSU-owned pending entry are dropped.
      wb_ok  = hz.lsu_wb_valid_i & pend_q[hz.lsu_wb_rd_i] & own_q[hz.lsu_wb_rd_i];
      ld_inc = issue & hz.dec_wr_lsu_i & (hz.dec_rd_i != 5'd0);

      pend_d = pend_q & ~reg_onehot(alu_exit_rd, alu_exit_vld)
                      & ~reg_onehot(hz.lsu_wb_rd_i, wb_ok);
      own_d  = own_q;
      if (issue && wr_any && (hz.dec_rd_i != 5'd0)) begin
         pend_d[hz.dec_rd_i] = 1'b1;
         own_d[hz.dec_rd_i]  = hz.dec_wr_lsu_i;
      end
      pend_d[0] = 1'b0;
      own_d[0]  = 1'b0;

      cnt_d = cnt_q;
      case ({ld_inc, wb_ok})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase

      state_d = state_q;
      case (state_q)
         HZD_RUN:   if (hz.dec_valid_i && hz.dec_fence_i && busy) state_d = HZD_DRAIN;
         HZD_DRAIN: if ((pend_q == '0) && (cnt_q == 3'd0))       state_d = HZD_RUN;
         default:   state_d = HZD_RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pend_q  <= '0;
         own_q   <= '0;
         cnt_q   <= 3'd0;
         state_q <= HZD_RUN;
      end else begin
         pend_q  <= pend_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign hz.stall_o     = stall;
   assign hz.issue_o     = issue;
   assign hz.busy_o      = busy;
   assign hz.loads_out_o = cnt_q;

   a_wb_legal: assert property (@(posedge clk_i) disable iff (!rstn_i)
      hz.lsu_wb_valid_i |-> (pend_q[hz.lsu_wb_rd_i] && own_q[hz.lsu_wb_rd_i]));

   a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
      hz.lsu_wb_valid_i |-> (cnt_q != 3'd0));

endmodule
